// File: rtl/pio_edge_capture_in.sv
// pio_edge_capture_in: synchronised PIO input port with sticky edge-capture and masked level interrupt.
module pio_edge_capture_in #(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1, sync2, prev, edge_det, edge_capture, irq_mask, edge_now, clr_mask;
    logic             wr_en, rd_en;
    logic [31:0]      rd_val;
    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;
    assign irq   = |(edge_capture & irq_mask);
    always_comb begin
        edge_now = EDGE_TYPE == 0 ? (sync2 & ~prev) : EDGE_TYPE == 1 ? (~sync2 & prev) : (sync2 ^ prev);
        clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        rd_val   = address == 2'd0 ? 32'(sync2) :
                   address == 2'd2 ? 32'(irq_mask) :
                   address == 2'd3 ? 32'(edge_capture) : 32'd0;
    end
    // edge_det registers the detected edge so capture lands one cycle after detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            edge_det     <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            sync1        <= in_port;
            sync2        <= sync1;
            prev         <= sync2;
            edge_det     <= edge_now;
            edge_capture <= (edge_capture & ~clr_mask) | edge_det;
            if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
            if (rd_en) readdata <= rd_val;
        end
    end
endmodule

// File: tb/tb_pio_edge_capture_in.sv
// tb_pio_edge_capture_in: directed checks of a rising-edge 32-bit port and an any-edge 8-bit port.
module tb_pio_edge_capture_in;
    logic        clk = 0, reset_n = 0, chipselect = 0, read_n = 1, write_n = 1;
    logic [1:0]  address = 0;
    logic [31:0] writedata = 0, in_a = 0, rdata_a, rdata_b;
    logic [7:0]  in_b = 0;
    logic        irq_a, irq_b;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    pio_edge_capture_in #(.WIDTH(32), .EDGE_TYPE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rdata_a), .irq(irq_a));
    pio_edge_capture_in #(.WIDTH(8), .EDGE_TYPE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rdata_b), .irq(irq_b));

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rd(input logic [1:0] a);
        chipselect = 1; read_n = 0; address = a;
        tick();
        chipselect = 0; read_n = 1;
    endtask

    initial begin
        tick(2);
        chk("reset_readdata", rdata_a, 0);
        chk("reset_irq", irq_a, 0);
        reset_n = 1;
        tick();
        wr(2, 32'h1);
        // rising capture latency: visible only after the fourth edge
        in_a = 32'h1;
        tick(3);
        chk("rise_not_yet", irq_a, 0);
        tick();
        chk("rise_irq", irq_a, 1);
        chipselect = 1; read_n = 0; address = 3;
        #2;
        chk("read_before_edge", rdata_a, 0);
        tick();
        chipselect = 0; read_n = 1;
        chk("read_ec", rdata_a, 32'h1);
        tick();
        chk("readdata_hold", rdata_a, 32'h1);
        // clear of one bit, irq follows mask
        in_a = 32'h5;
        tick(4);
        wr(2, 32'h4);
        chk("clr_irq_before", irq_a, 1);
        wr(3, 32'h4);
        chk("clr_irq_after", irq_a, 0);
        rd(3);
        chk("clr_ec", rdata_a, 32'h1);
        wr(0, 32'hFFFF_FFFF);
        wr(1, 32'hFFFF_FFFF);
        chipselect = 0; write_n = 0; address = 3; writedata = 32'hFF;
        tick();
        write_n = 1;
        rd(2);
        chk("ignored_mask", rdata_a, 32'h4);
        rd(3);
        chk("ignored_ec", rdata_a, 32'h1);
        // falling edge not captured in rising mode; then set beats clear
        in_a = 32'h4;
        tick(4);
        rd(3);
        chk("fall_ignored", rdata_a, 32'h1);
        wr(3, 32'h1);
        wr(2, 32'h1);
        chk("soc_irq_pre", irq_a, 0);
        in_a = 32'h5;
        tick(3);
        wr(3, 32'h1);
        chk("soc_irq", irq_a, 1);
        chipselect = 1; read_n = 0; write_n = 0; address = 3; writedata = 32'h1;
        tick();
        chipselect = 0; read_n = 1; write_n = 1;
        chk("rdclr_data", rdata_a, 32'h1);
        chk("rdclr_irq", irq_a, 0);
        rd(3);
        chk("rdclr_ec", rdata_a, 32'h0);
        // mask gating
        in_a = 32'hD;
        tick(4);
        wr(2, 32'h0);
        chk("mask0_irq", irq_a, 0);
        wr(2, 32'h8);
        chk("mask8_irq", irq_a, 1);
        rd(2);
        chk("mask_read", rdata_a, 32'h8);
        rd(3);
        chk("mask_ec", rdata_a, 32'h8);
        rd(0);
        chk("data_read", rdata_a, 32'hD);
        // build up edge_capture=0xFF, then reset mid-write
        in_a = 32'h0;
        tick(4);
        wr(3, 32'hFFFF_FFFF);
        in_a = 32'hFF;
        tick(4);
        wr(2, 32'hFF);
        chk("pre_reset_irq", irq_a, 1);
        rd(3);
        chk("pre_reset_ec", rdata_a, 32'hFF);
        chipselect = 1; write_n = 0; address = 2; writedata = 32'h55;
        reset_n = 0;
        #1;
        chk("async_readdata", rdata_a, 0);
        chk("async_irq", irq_a, 0);
        @(posedge clk);
        #1;
        chipselect = 0; write_n = 1;
        reset_n = 1;
        rd(2);
        chk("reset_mask", rdata_a, 0);
        rd(3);
        chk("reset_ec", rdata_a, 0);
        tick(2);
        rd(3);
        chk("reset_high_captured", rdata_a, 32'hFF);
        // any-edge, 8-bit port
        in_b = 8'h08;
        tick();
        rd(0);
        chk("b_data_lag1", rdata_b, 0);
        rd(0);
        chk("b_data_lag2", rdata_b, 32'h08);
        tick();
        in_b = 8'h00;
        rd(3);
        chk("b_rise_ec", rdata_b, 32'h08);
        wr(3, 32'h08);
        rd(3);
        chk("b_cleared", rdata_b, 0);
        tick();
        rd(3);
        chk("b_fall_ec", rdata_b, 32'h08);
        rd(1);
        chk("b_reserved", rdata_b, 0);
        rd(0);
        chk("b_data_low", rdata_b, 0);
        wr(2, 32'hFFFF_FF0F);
        chk("b_irq", irq_b, 1);
        rd(2);
        chk("b_mask_trunc", rdata_b, 32'h0F);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
